multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/mips_ctrl_pkg.sv | 60 ++++++
 rtl/multicycle_control_if.sv | 43 ++++
 rtl/opcode_decode.sv | 26 ++
 rtl/multicycle_control.sv | 188 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-style controller: opcodes, FSM state
// codes, datapath select encodings and the one-hot opcode class record.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_R      = 6'b000000;
   localparam logic [5:0] OP_LW     = 6'b100011;
   localparam logic [5:0] OP_SW     = 6'b101011;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_ORI    = 6'b001101;
   localparam logic [5:0] OP_BALN   = 6'b011011;
   localparam logic [5:0] OP_JPC    = 6'b011110;
   localparam logic [5:0] OP_BLTZAL = 6'b100010;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_REXEC  = 4'd6,
      S_RWB    = 4'd7,
      S_BRANCH = 4'd8,
      S_JPC    = 4'd9,
      S_ORIEX  = 4'd10,
      S_ORIWB  = 4'd11
   } state_t;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'd0,
      ALU_SUB   = 2'd1,
      ALU_FUNCT = 2'd2,
      ALU_OR    = 2'd3
   } aluop_t;

   typedef enum logic [1:0] {
      SRCB_REG   = 2'd0,
      SRCB_FOUR  = 2'd1,
      SRCB_IMM   = 2'd2,
      SRCB_SHIMM = 2'd3
   } srcb_t;

   typedef enum logic [1:0] {
      PC_ALU    = 2'd0,
      PC_ALUOUT = 2'd1,
      PC_JUMP   = 2'd2
   } pcsrc_t;

   typedef struct packed {
      logic r;
      logic lw;
      logic sw;
      logic beq;
      logic ori;
      logic baln;
      logic jpc;
      logic bltzal;
   } opclass_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: instruction/flag inputs and all control strobes.
interface multicycle_control_if #(
   parameter int unsigned OPW = 6
);
   logic [OPW-1:0] opcode;
   logic           zero;
   logic           neg;
   logic           status_n;
   logic           mem_ready;

   logic           pcwrite;
   logic           iord;
   logic           memread;
   logic           memwrite;
   logic           irwrite;
   logic           memtoreg;
   logic           regdest;
   logic           regwrite;
   logic           alusrca;
   logic [1:0]     alusrcb;
   logic [1:0]     aluop;
   logic [1:0]     pcsource;
   logic           link;
   logic [4:0]     wreg;
   logic [3:0]     state;
   logic           instr_done;
   logic           memerr;
   logic           illegal;

   modport master (
      input  opcode, zero, neg, status_n, mem_ready,
      output pcwrite, iord, memread, memwrite, irwrite, memtoreg, regdest,
             regwrite, alusrca, alusrcb, aluop, pcsource, link, wreg, state,
             instr_done, memerr, illegal
   );

   modport slave (
      output opcode, zero, neg, status_n, mem_ready,
      input  pcwrite, iord, memread, memwrite, irwrite, memtoreg, regdest,
             regwrite, alusrca, alusrcb, aluop, pcsource, link, wreg, state,
             instr_done, memerr, illegal
   );
endinterface

// File: rtl/opcode_decode.sv
// Combinational opcode classifier: one-hot instruction class plus illegal flag.
module opcode_decode
   import mips_ctrl_pkg::*;
(
   input  logic [5:0] i_opcode,
   output opclass_t   o_class,
   output logic       o_illegal
);

   always_comb begin
      o_class = '0;
      case (i_opcode)
         OP_R:      o_class.r      = 1'b1;
         OP_LW:     o_class.lw     = 1'b1;
         OP_SW:     o_class.sw     = 1'b1;
         OP_BEQ:    o_class.beq    = 1'b1;
         OP_ORI:    o_class.ori    = 1'b1;
         OP_BALN:   o_class.baln   = 1'b1;
         OP_JPC:    o_class.jpc    = 1'b1;
         OP_BLTZAL: o_class.bltzal = 1'b1;
         default:   ;
      endcase
      o_illegal = (o_class == '0);
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle controller FSM with memory-wait timeout, branch-and-link support
// and one-cycle retire/error pulses.
module multicycle_control
   import mips_ctrl_pkg::*;
#(
   parameter int unsigned LINKREG = 31,
   parameter int unsigned MEMTO   = 15,
   parameter int unsigned OPW     = 6
)(
   input  logic                 clk,
   input  logic                 reset,
   multicycle_control_if.master bus
);

   localparam logic [7:0] CNT_LAST = 8'(MEMTO - 1);

   state_t     r_state;
   state_t     w_next;
   logic [5:0] r_op;
   logic [7:0] r_cnt;

   logic [5:0] w_op;
   opclass_t   w_lc;
   opclass_t   w_rc;
   logic       w_lc_ill;
   logic       w_rc_ill;
   logic       w_wait_st;
   logic       w_timeout;
   logic       w_taken;
   logic       w_unused;

   assign w_op = bus.opcode[OPW-1:OPW-6];

   opcode_decode u_dec_live (.i_opcode(w_op), .o_class(w_lc), .o_illegal(w_lc_ill));
   opcode_decode u_dec_reg  (.i_opcode(r_op), .o_class(w_rc), .o_illegal(w_rc_ill));

   assign w_unused = ^{w_rc.r, w_rc.ori, w_rc.jpc, w_rc_ill};

   // Timeout fires on the MEMTO-th consecutive low cycle; a ready on that cycle wins.
   assign w_wait_st = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
   assign w_timeout = w_wait_st && !bus.mem_ready && (r_cnt == CNT_LAST);
   assign w_taken   = (w_rc.beq & bus.zero) | (w_rc.baln & bus.status_n) |
                      (w_rc.bltzal & bus.neg);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_FETCH;
         r_cnt   <= '0;
         r_op    <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_DECODE)
            r_op <= w_op;
         if ((w_next != r_state) || w_timeout)
            r_cnt <= '0;
         else if (!bus.mem_ready)
            r_cnt <= r_cnt + 8'd1;
      end
   end

   always_comb begin
      w_next         = r_state;
      bus.pcwrite    = 1'b0;
      bus.iord       = 1'b0;
      bus.memread    = 1'b0;
      bus.memwrite   = 1'b0;
      bus.irwrite    = 1'b0;
      bus.memtoreg   = 1'b0;
      bus.regdest    = 1'b0;
      bus.regwrite   = 1'b0;
      bus.alusrca    = 1'b0;
      bus.alusrcb    = SRCB_REG;
      bus.aluop      = ALU_ADD;
      bus.pcsource   = PC_ALU;
      bus.link       = 1'b0;
      bus.wreg       = '0;
      bus.state      = r_state;
      bus.instr_done = 1'b0;
      bus.memerr     = 1'b0;
      bus.illegal    = 1'b0;

      if (!reset) begin
         case (r_state)
            S_FETCH: begin
               bus.memread = 1'b1;
               bus.alusrcb = SRCB_FOUR;
               if (bus.mem_ready) begin
                  bus.irwrite = 1'b1;
                  bus.pcwrite = 1'b1;
                  w_next      = S_DECODE;
               end else if (w_timeout) begin
                  bus.memerr = 1'b1;
                  w_next     = S_FETCH;
               end
            end
            S_DECODE: begin
               bus.alusrcb = SRCB_SHIMM;
               if (w_lc.lw || w_lc.sw)                     w_next = S_MEMADR;
               else if (w_lc.r)                            w_next = S_REXEC;
               else if (w_lc.ori)                          w_next = S_ORIEX;
               else if (w_lc.beq || w_lc.baln || w_lc.bltzal) w_next = S_BRANCH;
               else if (w_lc.jpc)                          w_next = S_JPC;
               else begin
                  bus.illegal = w_lc_ill;
                  w_next      = S_FETCH;
               end
            end
            S_MEMADR: begin
               bus.alusrca = 1'b1;
               bus.alusrcb = SRCB_IMM;
               w_next      = w_rc.lw ? S_MEMRD : (w_rc.sw ? S_MEMWR : S_FETCH);
            end
            S_MEMRD: begin
               bus.memread = 1'b1;
               bus.iord    = 1'b1;
               if (bus.mem_ready) w_next = S_MEMWB;
               else if (w_timeout) begin
                  bus.memerr = 1'b1;
                  w_next     = S_FETCH;
               end
            end
            S_MEMWR: begin
               bus.memwrite = 1'b1;
               bus.iord     = 1'b1;
               if (bus.mem_ready) begin
                  bus.instr_done = 1'b1;
                  w_next         = S_FETCH;
               end else if (w_timeout) begin
                  bus.memerr = 1'b1;
                  w_next     = S_FETCH;
               end
            end
            S_MEMWB: begin
               bus.regwrite   = 1'b1;
               bus.memtoreg   = 1'b1;
               bus.instr_done = 1'b1;
               w_next         = S_FETCH;
            end
            S_REXEC: begin
               bus.alusrca = 1'b1;
               bus.aluop   = ALU_FUNCT;
               w_next      = S_RWB;
            end
            S_RWB: begin
               bus.regwrite   = 1'b1;
               bus.regdest    = 1'b1;
               bus.instr_done = 1'b1;
               w_next         = S_FETCH;
            end
            S_ORIEX: begin
               bus.alusrca = 1'b1;
               bus.alusrcb = SRCB_IMM;
               bus.aluop   = ALU_OR;
               w_next      = S_ORIWB;
            end
            S_ORIWB: begin
               bus.regwrite   = 1'b1;
               bus.instr_done = 1'b1;
               w_next         = S_FETCH;
            end
            S_BRANCH: begin
               bus.alusrca    = 1'b1;
               bus.aluop      = ALU_SUB;
               bus.pcsource   = PC_ALUOUT;
               bus.instr_done = 1'b1;
               bus.pcwrite    = w_taken;
               if (w_taken && (w_rc.baln || w_rc.bltzal)) begin
                  bus.regwrite = 1'b1;
                  bus.link     = 1'b1;
                  bus.wreg     = 5'(LINKREG);
               end
               w_next = S_FETCH;
            end
            S_JPC: begin
               bus.pcwrite    = 1'b1;
               bus.pcsource   = PC_JUMP;
               bus.regwrite   = 1'b1;
               bus.link       = 1'b1;
               bus.regdest    = 1'b1;
               bus.instr_done = 1'b1;
               w_next         = S_FETCH;
            end
            default: w_next = S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a per-cycle vector table plus
// hand-written memory-timeout and reset-abort sequences.
module tb_multicycle_control;

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, R = 6'b000000, BEQ = 6'b000100;
   localparam logic [5:0] ORI = 6'b001101, BALN = 6'b011011, JPC = 6'b011110;
   localparam logic [5:0] BLTZAL = 6'b100010, BAD = 6'b111111;

   // strobe order {pcwrite,iord,memread,memwrite,irwrite,memtoreg,regdest,regwrite,alusrca}
   localparam int PCW = 'h100, IORD = 'h080, MRD = 'h040, MWR = 'h020, IRW = 'h010;
   localparam int M2R = 'h008, RDST = 'h004, RW = 'h002, ASA = 'h001;
   localparam int FRD = PCW | MRD | IRW;
   // pulse order {instr_done,memerr,illegal}
   localparam int DONE = 4, ILL = 1;

   typedef struct {
      logic       rst;
      logic [5:0] op;
      logic [2:0] fl;   // {zero, neg, status_n}
      logic       rdy;
      logic [3:0] st;
      logic [8:0] strb;
      logic [1:0] srcb;
      logic [1:0] aop;
      logic [1:0] psrc;
      logic       lnk;
      logic [4:0] wr;
      logic [2:0] pul;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   multicycle_control_if #(.OPW(6)) if0 ();
   multicycle_control_if #(.OPW(6)) if1 ();

   assign if1.opcode    = if0.opcode;
   assign if1.zero      = if0.zero;
   assign if1.neg       = if0.neg;
   assign if1.status_n  = if0.status_n;
   assign if1.mem_ready = if0.mem_ready;

   multicycle_control u_dut (.clk(clk), .reset(reset), .bus(if0));
   multicycle_control #(.LINKREG(30)) u_dut30 (.clk(clk), .reset(reset), .bus(if1));

   function automatic vec_t row(int rst, int op, int fl, int rdy, int st, int strb,
                                int srcb, int aop, int psrc, int lnk, int wr, int pul);
      vec_t v;
      v.rst = 1'(rst);  v.op = 6'(op);     v.fl = 3'(fl);     v.rdy = 1'(rdy);
      v.st = 4'(st);    v.strb = 9'(strb); v.srcb = 2'(srcb); v.aop = 2'(aop);
      v.psrc = 2'(psrc); v.lnk = 1'(lnk);  v.wr = 5'(wr);     v.pul = 3'(pul);
      return v;
   endfunction

   function automatic logic [27:0] obs();
      return {if0.state, if0.pcwrite, if0.iord, if0.memread, if0.memwrite, if0.irwrite,
              if0.memtoreg, if0.regdest, if0.regwrite, if0.alusrca, if0.alusrcb, if0.aluop,
              if0.pcsource, if0.link, if0.wreg, if0.instr_done, if0.memerr, if0.illegal};
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //                  rst op  flags rdy st strobes        srcb aop psrc lnk wr pulse
      vecs.push_back(row(1, LW,    0, 1, 0,  0,              0, 0, 0, 0, 0,  0));
      vecs.push_back(row(0, LW,    0, 1, 0,  FRD,            1, 0, 0, 0, 0,  0));
      vecs.push_back(row(0, LW,    0, 1, 1,  0,              3, 0, 0, 0, 0,  0));
      vecs.push_back(row(0, R,     0, 1, 2,  ASA,            2, 0, 0, 0, 0,  0));
      vecs.push_back(row(0, R,     0, 1, 3,  IORD|MRD,       0, 0, 0, 0, 0,  0));
      vecs.push_back(row(0, R,     0, 1, 4,  RW|M2R,         0, 0, 0, 0, 0,  DONE));
      vecs.push_back(row(0, BEQ,   0, 1, 0,  FRD,            1, 0, 0, 0, 0,  0));
      vecs.push_back(row(0, BEQ,   0, 1, 1,  0,              3, 0, 0, 0, 0,  0));
      vecs.push_back(row(0, BEQ,   0, 1, 8,  ASA,            0, 1, 1, 0, 0,  DONE));
      vecs.push_back(row(0, BEQ,   4, 1, 0,  FRD,            1, 0, 0, 0, 0,  0));
      vecs.push_back(row(0, BEQ,   4, 1, 1,  0,              3, 0, 0, 0, 0,  0));
      vecs.push_back(row(0, BEQ,   4, 1, 8,  PCW|ASA,        0, 1, 1, 0, 0,  DONE));
      vecs.push_back(row(0, BLTZAL,2, 1, 0,  FRD,            1, 0, 0, 0, 0,  0));
      vecs.push_back(row(0, BLTZAL,2, 1, 1,  0,              3, 0, 0, 0, 0,  0));
      vecs.push_back(row(0, BLTZAL,2, 1, 8,  PCW|RW|ASA,     0, 1, 1, 1, 31, DONE));
      vecs.push_back(row(0, BAD,   0, 1, 0,  FRD,            1, 0, 0, 0, 0,  0));
      vecs.push_back(row(0, BAD,   0, 1, 1,  0,              3, 0, 0, 0, 0,  ILL));
      vecs.push_back(row(0, R,     0, 0, 0,  MRD,            1, 0, 0, 0, 0,  0));
      vecs.push_back(row(0, R,     0, 1, 0,  FRD,            1, 0, 0, 0, 0,  0));
      vecs.push_back(row(0, R,     0, 1, 1,  0,              3, 0, 0, 0, 0,  0));
      vecs.push_back(row(0, R,     0, 1, 6,  ASA,            0, 2, 0, 0, 0,  0));
      vecs.push_back(row(0, R,     0, 1, 7,  RW|RDST,        0, 0, 0, 0, 0,  DONE));
      vecs.push_back(row(0, ORI,   0, 1, 0,  FRD,            1, 0, 0, 0, 0,  0));
      vecs.push_back(row(0, ORI,   0, 1, 1,  0,              3, 0, 0, 0, 0,  0));
      vecs.push_back(row(0, ORI,   0, 1, 10, ASA,            2, 3, 0, 0, 0,  0));
      vecs.push_back(row(0, ORI,   0, 1, 11, RW,             0, 0, 0, 0, 0,  DONE));
      vecs.push_back(row(0, JPC,   0, 1, 0,  FRD,            1, 0, 0, 0, 0,  0));
      vecs.push_back(row(0, JPC,   0, 1, 1,  0,              3, 0, 0, 0, 0,  0));
      vecs.push_back(row(0, JPC,   0, 1, 9,  PCW|RW|RDST,    0, 0, 2, 1, 0,  DONE));
      vecs.push_back(row(0, BALN,  6, 1, 0,  FRD,            1, 0, 0, 0, 0,  0));
      vecs.push_back(row(0, BALN,  6, 1, 1,  0,              3, 0, 0, 0, 0,  0));
      vecs.push_back(row(0, BALN,  6, 1, 8,  ASA,            0, 1, 1, 0, 0,  DONE));
      vecs.push_back(row(0, BALN,  1, 1, 0,  FRD,            1, 0, 0, 0, 0,  0));
      vecs.push_back(row(0, BALN,  1, 1, 1,  0,              3, 0, 0, 0, 0,  0));
      vecs.push_back(row(0, BALN,  1, 1, 8,  PCW|RW|ASA,     0, 1, 1, 1, 31, DONE));
      vecs.push_back(row(0, SW,    0, 1, 0,  FRD,            1, 0, 0, 0, 0,  0));
      vecs.push_back(row(0, SW,    0, 1, 1,  0,              3, 0, 0, 0, 0,  0));
      vecs.push_back(row(0, SW,    0, 1, 2,  ASA,            2, 0, 0, 0, 0,  0));
      vecs.push_back(row(0, SW,    0, 1, 5,  IORD|MWR,       0, 0, 0, 0, 0,  DONE));
      vecs.push_back(row(0, R,     0, 0, 0,  MRD,            1, 0, 0, 0, 0,  0));

      reset = 1'b1;
      if0.opcode = '0;
      {if0.zero, if0.neg, if0.status_n} = 3'b000;
      if0.mem_ready = 1'b0;
      tick();
      tick();

      foreach (vecs[i]) begin
         reset = vecs[i].rst;
         if0.opcode = vecs[i].op;
         {if0.zero, if0.neg, if0.status_n} = vecs[i].fl;
         if0.mem_ready = vecs[i].rdy;
         @(negedge clk);
         chk($sformatf("vec%0d", i), {4'h0, obs()},
             {4'h0, vecs[i].st, vecs[i].strb, vecs[i].srcb, vecs[i].aop, vecs[i].psrc,
              vecs[i].lnk, vecs[i].wr, vecs[i].pul});
         if (vecs[i].lnk && vecs[i].wr == 5'd31)
            chk($sformatf("vec%0d_wreg_linkreg30", i), {27'h0, if1.wreg}, 32'd30);
         tick();
      end

      // sw with mem_ready low for the full window: timeout on the 15th low cycle
      if0.opcode = SW;
      if0.mem_ready = 1'b1;
      tick(); tick(); tick();
      if0.mem_ready = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         chk($sformatf("sw_to_cyc%0d", k), {26'h0, if0.state, if0.memwrite, if0.memerr},
             {26'h0, 4'd5, 1'b1, 1'(k == 15)});
         tick();
      end
      @(negedge clk);
      chk("sw_to_after", {25'h0, if0.state, if0.memwrite, if0.memread, if0.memerr},
          {25'h0, 4'd0, 1'b0, 1'b1, 1'b0});

      // sw with 14 low cycles then ready: completes normally
      if0.mem_ready = 1'b1;
      tick(); tick(); tick();
      if0.mem_ready = 1'b0;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         chk($sformatf("sw_14_cyc%0d", k), {27'h0, if0.state, if0.memerr}, {27'h0, 4'd5, 1'b0});
         tick();
      end
      if0.mem_ready = 1'b1;
      @(negedge clk);
      chk("sw_14_ready", {26'h0, if0.state, if0.memerr, if0.instr_done},
          {26'h0, 4'd5, 1'b0, 1'b1});
      tick();
      @(negedge clk);
      chk("sw_14_after", {28'h0, if0.state}, 32'd0);

      // reset while lw waits in MEMRD
      if0.opcode = LW;
      tick(); tick(); tick();
      if0.mem_ready = 1'b0;
      @(negedge clk);
      chk("rst_memrd_pre", {27'h0, if0.state, if0.memread}, {27'h0, 4'd3, 1'b1});
      tick();
      reset = 1'b1;
      if0.mem_ready = 1'b1;
      @(negedge clk);
      chk("rst_memrd_gate", {4'h0, obs()}, {4'h0, 4'd3, 24'h0});
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_memrd_after", {4'h0, obs()}, {4'h0, 4'd0, 9'(FRD), 2'd1, 2'd0, 2'd0, 1'b0, 5'd0, 3'd0});
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
